// File: rtl/tt_check_pkg.sv
// rtl/tt_check_pkg.sv - shared constants and state encoding for the truth-table checker
// Contents:
//   ST_IDLE, ST_RUN, ST_DONE : state encodings
//   IDX_W                    : width of the {x,y} truth-table index
//   state_e                  : FSM state type built on the encodings above
package tt_check_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int IDX_W = 2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_e;

endpackage

// File: rtl/tt_sat_cnt.sv
// rtl/tt_sat_cnt.sv - CNT_W-bit counter with clear and saturating increment
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset, clears the count
//   clr   : synchronous clear, wins over inc
//   inc   : increment by one unless already all-ones
//   cnt   : current count
module tt_sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/tt_checker.sv
// rtl/tt_checker.sv - compares sampled (x,y,z) against an expected 2-input truth table
// Parameters: EXP_TT (bit {x,y} = expected z), N_VEC (samples per run), CNT_W (counter width)
// Ports:
//   clk, rst_n             : clock and synchronous active-low reset
//   start                  : begin a run (IDLE/DONE only)
//   sample, x, y, z        : sample strobe and the gate inputs/output being checked
//   busy, done, pass       : state decode; pass = done with no mismatches
//   vec_cnt, err_cnt       : samples and (saturating) mismatches this run
//   fail_valid, fail_idx   : first mismatching {x,y} of this run
//   cov_mask               : only with TT_COVERAGE_EN; input combinations seen this run,
//                            and pass then also requires all four
module tt_checker
    import tt_check_pkg::*;
#(
    parameter logic [3:0] EXP_TT = 4'b1000,
    parameter int          N_VEC  = 4,
    parameter int          CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sample,
    input  logic             x,
    input  logic             y,
    input  logic             z,
`ifdef TT_COVERAGE_EN
    output logic [3:0]       cov_mask,
`endif
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             fail_valid,
    output logic [IDX_W-1:0] fail_idx
);

    state_e           state_q, state_d;
    logic             fail_valid_q, fail_valid_d;
    logic [IDX_W-1:0] fail_idx_q, fail_idx_d;

    logic [IDX_W-1:0] idx;
    logic             mismatch;
    logic             run_start;
    logic             accept;

    assign idx       = {x, y};
    // Case inequality so an X or Z on z is reported as a mismatch.
    assign mismatch  = (z !== EXP_TT[idx]);
    assign run_start = start && (state_q != S_RUN);
    assign accept    = sample && (state_q == S_RUN);

    always_comb begin
        state_d      = state_q;
        fail_valid_d = fail_valid_q;
        fail_idx_d   = fail_idx_q;
        if (run_start) begin
            state_d      = S_RUN;
            fail_valid_d = 1'b0;
            fail_idx_d   = '0;
        end else if (accept) begin
            if (mismatch && !fail_valid_q) begin
                fail_valid_d = 1'b1;
                fail_idx_d   = idx;
            end
            // vec_cnt still holds the pre-increment value here.
            if (vec_cnt == CNT_W'(N_VEC - 1)) begin
                state_d = S_DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            fail_valid_q <= 1'b0;
            fail_idx_q   <= '0;
        end else begin
            state_q      <= state_d;
            fail_valid_q <= fail_valid_d;
            fail_idx_q   <= fail_idx_d;
        end
    end

    tt_sat_cnt #(.CNT_W(CNT_W)) u_vec_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (run_start),
        .inc   (accept),
        .cnt   (vec_cnt)
    );

    tt_sat_cnt #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (run_start),
        .inc   (accept && mismatch),
        .cnt   (err_cnt)
    );

    assign busy       = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign fail_valid = fail_valid_q;
    assign fail_idx   = fail_idx_q;

`ifdef TT_COVERAGE_EN
    logic [3:0] cov_q, cov_d;

    always_comb begin
        cov_d = cov_q;
        if (run_start) begin
            cov_d = 4'h0;
        end else if (accept) begin
            cov_d[idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cov_q <= 4'h0;
        end else begin
            cov_q <= cov_d;
        end
    end

    assign cov_mask = cov_q;
    assign pass     = done && (err_cnt == '0) && (cov_q == 4'hF);
`else
    assign pass     = done && (err_cnt == '0);
`endif

endmodule
